// File: rtl/global_defs.sv
// Shared types for the DRAM controller model: parser opcodes, request queue state and entry.
package global_defs;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_IFETCH,
        OP_PREFETCH
    } parsed_op_t;

    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_ACTIVE,
        Q_FULL
    } queue_state_t;

    localparam int unsigned QUEUE_ADDRESS_WIDTH = 32;
    localparam int unsigned DEFAULT_QUEUE_DEPTH = 16;

    // Address field is sized for the parser's address output.
    typedef struct packed {
        parsed_op_t                     opcode;
        logic [QUEUE_ADDRESS_WIDTH-1:0] address;
        logic [31:0]                    arrival;
    } queue_entry_t;

endpackage

// File: rtl/request_queue_entry.sv
// One request queue slot: captured request plus a saturating age counter.
module request_queue_entry
    import global_defs::*;
#(
    parameter int unsigned AGE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  queue_entry_t         wr_data,
    input  logic                 age_en,
    output queue_entry_t         data,
    output logic [AGE_WIDTH-1:0] age
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            age  <= '0;
        end else if (wr_en) begin
            data <= wr_data;
            age  <= '0;
        end else if (age_en && (age != '1)) begin
            age <= age + AGE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/request_queue.sv
// Circular request queue between trace parser and DRAM scheduler, with per-entry ageing.
// Define REQUEST_QUEUE_STATS_EN to add high_water and full_cycles statistics outputs.
module request_queue
    import global_defs::*;
#(
    parameter int unsigned ADDRESS_WIDTH = QUEUE_ADDRESS_WIDTH,
    parameter int unsigned DEPTH         = DEFAULT_QUEUE_DEPTH,
    parameter int unsigned AGE_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_ready_s,
    input  parsed_op_t                 opcode,
    input  logic [ADDRESS_WIDTH-1:0]   address,
    input  logic [31:0]                CPU_cycle_count,
    output logic                       queue_full,
    output logic                       dq_valid,
    output parsed_op_t                 dq_opcode,
    output logic [ADDRESS_WIDTH-1:0]   dq_address,
    output logic [31:0]                dq_arrival,
    output logic [AGE_WIDTH-1:0]       dq_age,
    input  logic                       dq_pop,
    output logic [$clog2(DEPTH):0]     occupancy,
    output queue_state_t               state
`ifdef REQUEST_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]     high_water,
    output logic [31:0]                full_cycles
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    queue_state_t     state_q, state_d;
    logic             push, pop;
    queue_entry_t     wr_entry;
    queue_entry_t     slot_data [DEPTH];
    logic [AGE_WIDTH-1:0] slot_age [DEPTH];

    // Full/empty gating uses registered count, so a push against a full queue is refused
    // even when a pop retires the head on the same edge.
    assign push = op_ready_s && (count_q != FULL_COUNT);
    assign pop  = dq_pop && (count_q != '0);

    always_comb begin
        wr_entry         = '0;
        wr_entry.opcode  = opcode;
        wr_entry.address = QUEUE_ADDRESS_WIDTH'(address);
        wr_entry.arrival = CPU_cycle_count;
    end

    always_comb begin
        head_d  = pop ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gen_slot
        logic [PTR_W-1:0] slot_offset;
        logic             slot_valid;

        // Distance from head in arrival order; slot holds a live request if within count.
        assign slot_offset = PTR_W'(g) - head_q;
        assign slot_valid  = {1'b0, slot_offset} < count_q;

        request_queue_entry #(
            .AGE_WIDTH(AGE_WIDTH)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (push && (tail_q == PTR_W'(g))),
            .wr_data (wr_entry),
            .age_en  (slot_valid),
            .data    (slot_data[g]),
            .age     (slot_age[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= Q_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = Q_ACTIVE;
        if (count_d == '0) begin
            state_d = Q_EMPTY;
        end else if (count_d == FULL_COUNT) begin
            state_d = Q_FULL;
        end
    end

    always_comb begin
        queue_full = (state_q == Q_FULL);
        dq_valid   = (state_q != Q_EMPTY);
    end

    assign dq_opcode  = slot_data[head_q].opcode;
    assign dq_address = ADDRESS_WIDTH'(slot_data[head_q].address);
    assign dq_arrival = slot_data[head_q].arrival;
    assign dq_age     = slot_age[head_q];
    assign occupancy  = count_q;
    assign state      = state_q;

`ifdef REQUEST_QUEUE_STATS_EN
    logic [CNT_W-1:0] high_water_q;
    logic [31:0]      full_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_water_q  <= '0;
            full_cycles_q <= '0;
        end else begin
            if (count_d > high_water_q) begin
                high_water_q <= count_d;
            end
            if (queue_full && (full_cycles_q != '1)) begin
                full_cycles_q <= full_cycles_q + 32'd1;
            end
        end
    end

    assign high_water  = high_water_q;
    assign full_cycles = full_cycles_q;
`endif

endmodule

// File: doc/request_queue.md
Name: request_queue

Overview:
- Memory request queue directly downstream of the trace parser in the DRAM controller model.
- Captures each parsed operation (opcode, address, arrival CPU cycle) when the parser asserts op_ready_s.
- Holds up to DEPTH outstanding requests in arrival order and ages every entry each clock.
- Presents the oldest request to the DRAM command scheduler, and back-pressures the parser when full.

Parameters:
- ADDRESS_WIDTH, 32, width of request address (matches parser output).
- DEPTH, 16, number of queue entries; power of two, at least 2.
- AGE_WIDTH, 16, width of per-entry age counter; saturating.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- op_ready_s  input  1  parser has a valid request this cycle.
- opcode  input  parsed_op_t  parsed operation type.
- address  input  ADDRESS_WIDTH  request address.
- CPU_cycle_count  input  32  CPU cycle at which the request arrived.
- queue_full  output  1  no free entry; parser must hold its request.
- dq_valid  output  1  head entry valid.
- dq_opcode  output  parsed_op_t  head opcode.
- dq_address  output  ADDRESS_WIDTH  head address.
- dq_arrival  output  32  head arrival CPU cycle.
- dq_age  output  AGE_WIDTH  cycles the head has spent in the queue.
- dq_pop  input  1  scheduler retires the head entry this cycle.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.
- state  output  queue_state_t  Q_EMPTY / Q_ACTIVE / Q_FULL.

Behaviour:
- Storage is a circular buffer with head pointer, tail pointer, and a count register. All outputs are registered or decoded from registers only; there is no fall-through.
- Reset, asynchronous:
  - Pointers, count and all ages go to 0.
  - queue_full=0, dq_valid=0, dq_opcode=0, dq_address=0, dq_arrival=0, dq_age=0, occupancy=0, state=Q_EMPTY.
  - Reset mid-operation discards all entries; no request survives.
- Push:
  - Accepted on a rising edge when op_ready_s=1 and count<DEPTH.
  - The entry {opcode, address, CPU_cycle_count, age=0} is written at the tail, and the tail wraps modulo DEPTH.
- Pop:
  - Accepted on a rising edge when dq_pop=1 and count>0; the head advances modulo DEPTH.
  - dq_pop while empty is ignored: no pointer or count change.
- Simultaneous push and pop:
  - With 0<count<DEPTH, both take effect and count is unchanged.
  - When full, only the pop takes effect. The push is refused and the parser re-presents next cycle, because queue_full is decoded from registered count.
  - When empty, only the push takes effect.
- Latency: a request pushed at edge N is visible at the head (dq_valid=1) from edge N+1 if the queue was empty.
- Ageing:
  - Every valid entry's age increments by 1 each clock, saturating at 2^AGE_WIDTH-1.
  - A newly written entry starts at 0, so dq_age reads 0 in its first visible cycle.
- State machine, derived from the next count:
  - Q_EMPTY when count=0.
  - Q_FULL when count=DEPTH.
  - Q_ACTIVE otherwise.
  - Transitions EMPTY->ACTIVE, ACTIVE->FULL, FULL->ACTIVE and ACTIVE->EMPTY each occur on the edge that changes count across the boundary.
  - DEPTH=1 behaviour is undefined (excluded by the DEPTH parameter rule).
- queue_full = (count==DEPTH); dq_valid = (count!=0).
- Head outputs hold their last value when dq_valid=0. They are don't-care for checking.

Optional Feature:
- Macro: REQUEST_QUEUE_STATS_EN.
- When defined, adds two output ports:
  - high_water, $clog2(DEPTH)+1 bits: maximum occupancy since reset.
  - full_cycles, 32 bits: saturating count of clocks with queue_full=1.
  - Both reset to 0.
- When undefined, neither port nor its logic exists, and the remaining behaviour is identical.

Decomposition:
- Shared package global_defs holds:
  - parsed_op_t (already existing, used unchanged).
  - New queue_state_t enum {Q_EMPTY, Q_ACTIVE, Q_FULL}.
  - New queue_entry_t struct {opcode, address, arrival}.
  - DEFAULT_QUEUE_DEPTH=16.
- One sub-module is natural: request_queue_entry, one storage slot holding data plus a saturating age counter, instantiated DEPTH times via generate.

Test Plan:
- Reset then push READ @0x0000_1000 at cycle 5 -> next edge dq_valid=1, dq_address=0x0000_1000, dq_arrival=5, dq_age=0, occupancy=1, state=Q_ACTIVE.
- Push 16 requests with no pops -> queue_full=1, state=Q_FULL. A 17th op_ready_s is held unaccepted until one pop. The 17th then appears in order after the other 16, and pops return the addresses in push order.
- Full queue with op_ready_s=1 and dq_pop=1 on the same edge -> occupancy goes 16->15, the push is not taken, and the following edge accepts it (occupancy back to 16).
- Single entry left un-popped for 20 cycles -> dq_age=20. With AGE_WIDTH=4 it saturates at 15 and stays there.
- dq_pop=1 on an empty queue for 3 cycles -> occupancy stays 0, state=Q_EMPTY, pointers unchanged (next push appears normally).
- Assert rst mid-stream with 7 entries -> all outputs immediately return to reset values without waiting for clk; after release, the first new push is the only entry.
